// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor. Each SLICE-bit slice adds in its own stage with a
// registered carry between stages. Valid/ready flow control stalls the whole pipe at once.
module rca_pipe #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);
    localparam int NSTAGE = WIDTH / SLICE;

    if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_param_check
        $error("rca_pipe: WIDTH (%0d) must be a positive multiple of SLICE (%0d)", WIDTH, SLICE);
    end

    logic              advance;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [NSTAGE-1:0] v_q;

    assign advance = ~o_valid | o_ready;
    assign i_ready = advance;
    assign b_eff   = sub ? ~b : b;
    assign c0      = sub | ci;

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
        end else if (advance) begin
            v_q[0] <= i_valid;
            for (int unsigned i = 1; i < NSTAGE; i++) begin
                v_q[i] <= v_q[i-1];
            end
        end
    end

    assign o_valid = v_q[NSTAGE-1];

    for (genvar j = 0; j < NSTAGE; j++) begin : g_slice
        localparam int LO = j * SLICE;

        logic [SLICE-1:0] op_a;
        logic [SLICE-1:0] op_b;
        logic             cin;
        logic [SLICE:0]   sum;
        logic             c_q;
        logic [SLICE-1:0] s_d [NSTAGE-j];

        if (j == 0) begin : g_head
            assign op_a = a[LO +: SLICE];
            assign op_b = b_eff[LO +: SLICE];
            assign cin  = c0;
        end else begin : g_skew
            // Operand slice j waits j cycles so it meets the carry leaving slice j-1.
            logic [SLICE-1:0] a_d [j];
            logic [SLICE-1:0] b_d [j];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int unsigned i = 0; i < j; i++) begin
                        a_d[i] <= '0;
                        b_d[i] <= '0;
                    end
                end else if (advance) begin
                    a_d[0] <= a[LO +: SLICE];
                    b_d[0] <= b_eff[LO +: SLICE];
                    for (int unsigned i = 1; i < j; i++) begin
                        a_d[i] <= a_d[i-1];
                        b_d[i] <= b_d[i-1];
                    end
                end
            end

            assign op_a = a_d[j-1];
            assign op_b = b_d[j-1];
            assign cin  = g_slice[j-1].c_q;
        end

        assign sum = {1'b0, op_a} + {1'b0, op_b} + {{SLICE{1'b0}}, cin};

        // Finished sum slices are delayed so every slice reaches s on the same cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                c_q <= 1'b0;
                for (int unsigned i = 0; i < NSTAGE - j; i++) begin
                    s_d[i] <= '0;
                end
            end else if (advance) begin
                c_q    <= sum[SLICE];
                s_d[0] <= sum[SLICE-1:0];
                for (int unsigned i = 1; i < NSTAGE - j; i++) begin
                    s_d[i] <= s_d[i-1];
                end
            end
        end

        assign s[LO +: SLICE] = s_d[NSTAGE-1-j];

        if (j == NSTAGE - 1) begin : g_msb
            logic ov_q;

            // a ^ b' ^ sum at the MSB recovers the carry into it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ov_q <= 1'b0;
                end else if (advance) begin
                    ov_q <= op_a[SLICE-1] ^ op_b[SLICE-1] ^ sum[SLICE-1] ^ sum[SLICE];
                end
            end
        end
    end

    assign co = g_slice[NSTAGE-1].c_q;
    assign ov = g_slice[NSTAGE-1].g_msb.ov_q;

endmodule

// File: tb/tb_rca_pipe.sv
// Bench for rca_pipe: directed corner cases, randomized streaming with bubbles and backpressure,
// reset while busy, and a width/slice sweep, all checked against an integer-arithmetic model.
module tb_rca_pipe;
    localparam int NST = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] s;
    logic        co;
    logic        ov;

    logic [63:0] sw_a;
    logic [63:0] sw_b;
    logic        sw_ci;
    logic        sw_sub;
    logic        sw_iv;
    logic        sw_ordy;
    logic        ir8, vld8, co8, ovf8;
    logic [7:0]  s8;
    logic        ir16, vld16, co16, ovf16;
    logic [15:0] s16;
    logic        ir64, vld64, co64, ovf64;
    logic [63:0] s64;

    int n_vec = 0;
    int n_bad = 0;
    bit acc_hist [512];

    rca_pipe #(.WIDTH(32), .SLICE(4)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .o_valid(o_valid), .o_ready(o_ready), .s(s), .co(co), .ov(ov)
    );

    rca_pipe #(.WIDTH(8), .SLICE(1)) u_w8 (
        .clk(clk), .reset(reset), .i_valid(sw_iv), .i_ready(ir8),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .ci(sw_ci), .sub(sw_sub),
        .o_valid(vld8), .o_ready(sw_ordy), .s(s8), .co(co8), .ov(ovf8)
    );

    rca_pipe #(.WIDTH(16), .SLICE(16)) u_w16 (
        .clk(clk), .reset(reset), .i_valid(sw_iv), .i_ready(ir16),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .ci(sw_ci), .sub(sw_sub),
        .o_valid(vld16), .o_ready(sw_ordy), .s(s16), .co(co16), .ov(ovf16)
    );

    rca_pipe #(.WIDTH(64), .SLICE(8)) u_w64 (
        .clk(clk), .reset(reset), .i_valid(sw_iv), .i_ready(ir64),
        .a(sw_a), .b(sw_b), .ci(sw_ci), .sub(sw_sub),
        .o_valid(vld64), .o_ready(sw_ordy), .s(s64), .co(co64), .ov(ovf64)
    );

    always #5 clk = ~clk;

    // Plain arithmetic: unsigned result gives s/co, exact signed result gives ov by range check.
    function automatic void model(input int w, input logic [63:0] ma, input logic [63:0] mb,
                                  input logic mci, input logic msub,
                                  output logic [63:0] ms, output logic mco, output logic mov);
        logic [63:0]        mask;
        logic [64:0]        ua, ub, u;
        logic signed [66:0] sa, sb, r, lim;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ua = {1'b0, ma & mask};
        ub = {1'b0, mb & mask};
        if (msub) begin
            u   = ua - ub;
            mco = (ua >= ub);
        end else begin
            u   = ua + ub + {64'd0, mci};
            mco = u[w];
        end
        ms = u[63:0] & mask;
        sa = $signed({2'b00, ua});
        sb = $signed({2'b00, ub});
        if (ma[w-1]) sa = sa - (67'sd1 <<< w);
        if (mb[w-1]) sb = sb - (67'sd1 <<< w);
        if (msub) r = sa - sb;
        else      r = sa + sb + (mci ? 67'sd1 : 67'sd0);
        lim = 67'sd1 <<< (w - 1);
        mov = (r >= lim) || (r < -lim);
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb2, input logic tci,
                         input logic tsub, input logic [31:0] es, input logic eco,
                         input logic eov, input string nm);
        int edges;
        a = ta; b = tb2; ci = tci; sub = tsub; i_valid = 1'b1; o_ready = 1'b1;
        #1;
        n_vec++;
        if (i_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_ready got i_ready=%b want 1", nm, i_ready);
        end
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        i_valid = 1'b0;
        while (o_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        n_vec++;
        if (edges != NST) begin
            n_bad++;
            $display("FAIL %s_latency got %0d edges want %0d", nm, edges, NST);
        end
        n_vec++;
        if ({s, co, ov} !== {es, eco, eov}) begin
            n_bad++;
            $display("FAIL %s got s=%h co=%b ov=%b want s=%h co=%b ov=%b", nm, s, co, ov, es, eco, eov);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_pop got o_valid=%b want 0", nm, o_valid);
        end
    endtask

    task automatic do_rand_op(input string nm);
        logic [31:0] ta, tb2;
        logic        tci, tsub, mco, mov;
        logic [63:0] ms;
        ta = $urandom; tb2 = $urandom; tci = 1'($urandom_range(1)); tsub = 1'($urandom_range(1));
        model(32, {32'd0, ta}, {32'd0, tb2}, tci, tsub, ms, mco, mov);
        do_op(ta, tb2, tci, tsub, ms[31:0], mco, mov, nm);
    endtask

    // Drives a stream at negedges, pops results in order from a queue of model results.
    task automatic run_stream(input int n, input int bubble_pct, input int stall_lo,
                              input int stall_hi, input bit consec, input bit gaps, input string nm);
        int          pushed, popped, cyc, first_pop, last_pop;
        logic        hold, acc, exp_v;
        logic [33:0] held, want;
        logic [63:0] ms;
        logic        mco, mov;
        logic [33:0] q [$];
        pushed = 0; popped = 0; cyc = 0; first_pop = -1; last_pop = -1;
        hold = 1'b0; acc = 1'b0; held = '0;
        i_valid = 1'b0;
        while ((pushed < n || q.size() != 0) && cyc < 4 * n + 100) begin
            if (hold) begin
                n_vec++;
                if (o_valid !== 1'b1 || {s, co, ov} !== held) begin
                    n_bad++;
                    $display("FAIL %s_stable cyc=%0d got v=%b %h want v=1 %h", nm, cyc, o_valid, {s, co, ov}, held);
                end
            end
            if (gaps) begin
                exp_v = (cyc >= NST) ? acc_hist[cyc - NST] : 1'b0;
                n_vec++;
                if (o_valid !== exp_v) begin
                    n_bad++;
                    $display("FAIL %s_gap cyc=%0d got o_valid=%b want %b", nm, cyc, o_valid, exp_v);
                end
            end
            o_ready = !(cyc >= stall_lo && cyc <= stall_hi);
            if (o_valid === 1'b1 && o_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s_extra cyc=%0d got %h want no result", nm, cyc, {s, co, ov});
                end else begin
                    want = q.pop_front();
                    if ({s, co, ov} !== want) begin
                        n_bad++;
                        $display("FAIL %s_data cyc=%0d got %h want %h", nm, cyc, {s, co, ov}, want);
                    end
                end
                popped++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            hold = (o_valid === 1'b1) && !o_ready;
            held = {s, co, ov};
            if (!i_valid || acc) begin
                i_valid = (pushed < n) && ($urandom_range(99) >= bubble_pct);
                a = $urandom; b = $urandom;
                ci = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
            end
            #1;
            n_vec++;
            if (i_ready !== (!o_valid || o_ready)) begin
                n_bad++;
                $display("FAIL %s_ready cyc=%0d got i_ready=%b o_valid=%b o_ready=%b", nm, cyc, i_ready, o_valid, o_ready);
            end
            acc = i_valid && i_ready;
            acc_hist[cyc] = acc;
            if (acc) begin
                model(32, {32'd0, a}, {32'd0, b}, ci, sub, ms, mco, mov);
                q.push_back({ms[31:0], mco, mov});
                pushed++;
            end
            @(negedge clk);
            cyc++;
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        n_vec++;
        if (q.size() != 0 || popped != n) begin
            n_bad++;
            $display("FAIL %s_count got popped=%0d pending=%0d want popped=%0d pending=0", nm, popped, q.size(), n);
        end
        if (consec) begin
            n_vec++;
            if (last_pop - first_pop != n - 1) begin
                n_bad++;
                $display("FAIL %s_rate got span=%0d want %0d", nm, last_pop - first_pop, n - 1);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0; sw_iv = 1'b0; sw_ordy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if ({o_valid, i_ready, co, ov} !== 4'b0100) begin
            n_bad++;
            $display("FAIL reset_flags got v/rdy/co/ov=%b want 0100", {o_valid, i_ready, co, ov});
        end
        n_vec++;
        if (s !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_sum got %h want 00000000", s);
        end
        n_vec++;
        if ({vld8, vld16, vld64, s64} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_sweep got v=%b%b%b s64=%h want 0", vld8, vld16, vld64, s64);
        end
    endtask

    task automatic test_add();
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, "add_ripple");
        do_op(32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ci_ov");
        do_rand_op("add_rand0");
        do_rand_op("add_rand1");
    endtask

    task automatic test_sub_overflow();
        do_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ov");
        do_op(32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
        do_op(32'd5, 32'd5, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0, "sub_ci_ignored");
    endtask

    task automatic test_back_to_back();
        run_stream(20, 0, -1, -2, 1'b1, 1'b0, "b2b");
    endtask

    task automatic test_backpressure();
        run_stream(40, 25, 10, 14, 1'b0, 1'b0, "bp");
    endtask

    task automatic test_bubbles();
        run_stream(30, 40, -1, -2, 1'b0, 1'b1, "bubble");
    endtask

    task automatic test_reset_midflight();
        o_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
            i_valid = 1'b1;
            @(negedge clk);
        end
        i_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (s !== 32'd0) begin
            n_bad++;
            $display("FAIL midreset_sum got %h want 00000000", s);
        end
        for (int i = 0; i < NST + 2; i++) begin
            n_vec++;
            if (o_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_valid cyc=%0d got o_valid=%b want 0", i, o_valid);
            end
            @(negedge clk);
        end
        do_rand_op("midreset_next");
    endtask

    task automatic test_sweep();
        logic        hv [41];
        logic [63:0] ha [41];
        logic [63:0] hb [41];
        logic        hci [41];
        logic        hsub [41];
        for (int t = 1; t <= 40; t++) begin
            hv[t] = (t <= 30) && ($urandom_range(99) < 80);
            ha[t] = {$urandom, $urandom};
            hb[t] = {$urandom, $urandom};
            hci[t] = 1'($urandom_range(1));
            hsub[t] = 1'($urandom_range(1));
            sw_iv = hv[t]; sw_a = ha[t]; sw_b = hb[t]; sw_ci = hci[t]; sw_sub = hsub[t];
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int          w, l, idx;
                logic        gv, gr, gco, gov, ev, eco, eov;
                logic [63:0] gs, es;
                case (k)
                    0:       begin w = 8;  l = 8; gv = vld8;  gr = ir8;  gs = {56'd0, s8};  gco = co8;  gov = ovf8;  end
                    1:       begin w = 16; l = 1; gv = vld16; gr = ir16; gs = {48'd0, s16}; gco = co16; gov = ovf16; end
                    default: begin w = 64; l = 8; gv = vld64; gr = ir64; gs = s64;          gco = co64; gov = ovf64; end
                endcase
                idx = t - l + 1;
                ev = (idx >= 1) && hv[idx];
                n_vec++;
                if (gv !== ev || gr !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sweep_w%0d_valid t=%0d got v=%b rdy=%b want v=%b rdy=1", w, t, gv, gr, ev);
                end
                if (ev) begin
                    model(w, ha[idx], hb[idx], hci[idx], hsub[idx], es, eco, eov);
                    n_vec++;
                    if ({gs, gco, gov} !== {es, eco, eov}) begin
                        n_bad++;
                        $display("FAIL sweep_w%0d_data t=%0d got s=%h co=%b ov=%b want s=%h co=%b ov=%b",
                                 w, t, gs, gco, gov, es, eco, eov);
                    end
                end
            end
        end
        sw_iv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_overflow();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_reset_midflight();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
